// File: rtl/mem_pkg.sv
// Shared types and sizing for the store buffer and its forwarding search.
package mem_pkg;

  localparam int SB_DEPTH = 4;   // buffered stores
  localparam int DM_AW    = 10;  // data-memory word-index width (1024 words)

  // One buffered store: originating PC, byte address, data word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;

  // Width of the circular-buffer read/write pointers.
  function automatic int sb_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search across buffered stores for load forwarding.
// Entries are visited from oldest to youngest relative to the write pointer,
// so the last match seen is the youngest and its data is returned.
module sb_fwd_match
  import mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = DM_AW,
  localparam int PW   = sb_ptr_w(DEPTH)
) (
  input  sb_entry_t         entries_i [DEPTH],
  input  logic [DEPTH-1:0]  occ_i,
  input  logic [PW-1:0]     wp_i,
  input  logic [AW-1:0]     ld_idx_i,
  output logic              hit_o,
  output logic [31:0]       data_o
);

  logic [PW-1:0] idx;
  logic          entries_unused;

  // Priority search: age walks from DEPTH (oldest slot) down to 1 (youngest).
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    // NOTE: blocking assignments in a combinational loop act in order, so a
    // later (younger) match overwrites an earlier one; the defaults above
    // keep every path assigned and prevent latch inference.
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wp_i - PW'(k);
      if (occ_i[idx] && (entries_i[idx].addr[AW+1:2] == ld_idx_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

  // PC and the non-index address bits take no part in the match.
  always_comb begin
    entries_unused = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      entries_unused = entries_unused ^ (^entries_i[i]);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Word-store FIFO between the execute/memory datapath and data memory.
// Accepts stores on a valid/ready handshake, drains one per cycle in order,
// and forwards the youngest pending store data to a matching load.
module store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = DM_AW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_pc,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [31:0]              ld_addr,
  output logic                     ld_hit,
  output logic [31:0]              ld_data,
  input  logic                     dm_ready,
  output logic                     dm_we,
  output logic [31:0]              dm_pc,
  output logic [31:0]              dm_addr,
  output logic [AW-1:0]            dm_A,
  output logic [31:0]              dm_wd,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = sb_ptr_w(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t        mem_q [DEPTH];
  sb_entry_t        head;
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] occ;
  logic [PW-1:0]    off;
  logic             push, pop;
  logic             ld_addr_unused;

  // Handshake and status come only from registered occupancy: no full-bypass.
  assign st_ready = (count_q != CW'(DEPTH));
  assign dm_we    = (count_q != '0);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign push     = st_valid && st_ready;
  assign pop      = dm_we && dm_ready;

  // Head entry drives the memory write port; all zero while empty.
  assign head    = mem_q[rp_q];
  assign dm_pc   = dm_we ? head.pc   : '0;
  assign dm_addr = dm_we ? head.addr : '0;
  assign dm_A    = dm_we ? head.addr[AW+1:2] : '0;
  assign dm_wd   = dm_we ? head.data : '0;

  // Only the word index of the load address selects a buffered store.
  assign ld_addr_unused = ^{ld_addr[31:AW+2], ld_addr[1:0]};

  // Pointer and occupancy next-state.
  always_comb begin
    wp_d    = push ? wp_q + PW'(1) : wp_q;
    rp_d    = pop  ? rp_q + PW'(1) : rp_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Slot i is occupied when its distance from rp is below count.
  always_comb begin
    occ = '0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off    = PW'(i) - rp_q;
      occ[i] = (CW'(off) < count_q);
    end
  end

  // FIFO control registers; reset discards every pending store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Entry storage, written at wp on a push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the entry array is cleared on reset so that forwarding and the
      // dm_* outputs never see X in simulation; the contents are otherwise
      // don't-care because occupancy masks them.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wp_q] <= '{pc: st_pc, addr: st_addr, data: st_data};
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fwd (
    .entries_i (mem_q),
    .occ_i     (occ),
    .wp_i      (wp_q),
    .ld_idx_i  (ld_addr[AW+1:2]),
    .hit_o     (ld_hit),
    .data_o    (ld_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer (DEPTH=4, AW=10): directed scenarios
// followed by randomized traffic against a queue-based reference model.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_pc, st_addr, st_data;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        dm_ready;
  logic        dm_we;
  logic [31:0] dm_pc, dm_addr, dm_wd;
  logic [9:0]  dm_A;
  logic [2:0]  count;
  logic        empty;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  store_buffer dut (
    .clk      (clk),
    .reset    (reset),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_pc    (st_pc),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_data  (ld_data),
    .dm_ready (dm_ready),
    .dm_we    (dm_we),
    .dm_pc    (dm_pc),
    .dm_addr  (dm_addr),
    .dm_A     (dm_A),
    .dm_wd    (dm_wd),
    .count    (count),
    .empty    (empty)
  );

  // Advance past the next rising edge; outputs are then sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] addr,
                          input logic [31:0] data);
    st_valid = 1'b1;
    st_pc    = pc;
    st_addr  = addr;
    st_data  = data;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({count, st_ready, empty, dm_we, dm_pc, dm_addr, dm_A, dm_wd, ld_hit, ld_data}
        !== {3'd0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 10'd0, 32'd0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got cnt=%0d rdy=%b emp=%b we=%b pc=%h addr=%h A=%h wd=%h hit=%b ld=%h, required cnt=0 rdy=1 emp=1 we=0 all data 0",
               count, st_ready, empty, dm_we, dm_pc, dm_addr, dm_A, dm_wd, ld_hit, ld_data);
    end
    #1;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_store();
    dm_ready = 1'b1;
    push_one(32'h3000, 32'h10, 32'hDEADBEEF);
    n_checks++;
    if ({dm_we, dm_A, dm_wd, dm_pc, dm_addr, count} !==
        {1'b1, 10'd4, 32'hDEADBEEF, 32'h3000, 32'h10, 3'd1}) begin
      n_fail++;
      $display("FAIL single_head: got we=%b A=%0d wd=%h pc=%h addr=%h cnt=%0d, required we=1 A=4 wd=deadbeef pc=3000 addr=10 cnt=1",
               dm_we, dm_A, dm_wd, dm_pc, dm_addr, count);
    end
    tick();
    n_checks++;
    if ({empty, dm_we, dm_wd} !== {1'b1, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL single_drained: got empty=%b we=%b wd=%h, required empty=1 we=0 wd=0",
               empty, dm_we, dm_wd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_wd [5];
    logic [2:0]  exp_cnt [5];
    dm_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(32'h4000 + 4 * i, 32'h40 + 4 * i, 32'h100 + i);
    n_checks++;
    if ({st_ready, count, dm_wd} !== {1'b0, 3'd4, 32'h100}) begin
      n_fail++;
      $display("FAIL bp_full: got rdy=%b cnt=%0d wd=%h, required rdy=0 cnt=4 wd=100",
               st_ready, count, dm_wd);
    end
    // Fifth store is presented and held while the buffer is full.
    st_valid = 1'b1;
    st_pc    = 32'h4010;
    st_addr  = 32'h50;
    st_data  = 32'h104;
    tick();
    tick();
    n_checks++;
    if ({st_ready, count, dm_wd} !== {1'b0, 3'd4, 32'h100}) begin
      n_fail++;
      $display("FAIL bp_held: got rdy=%b cnt=%0d wd=%h, required rdy=0 cnt=4 wd=100",
               st_ready, count, dm_wd);
    end
    dm_ready = 1'b1;
    tick();  // pop only: full buffer refuses the push
    n_checks++;
    if ({st_ready, count, dm_wd} !== {1'b1, 3'd3, 32'h101}) begin
      n_fail++;
      $display("FAIL bp_first_pop: got rdy=%b cnt=%0d wd=%h, required rdy=1 cnt=3 wd=101",
               st_ready, count, dm_wd);
    end
    tick();  // held store accepted together with a pop
    st_valid = 1'b0;
    exp_wd  = '{32'h102, 32'h103, 32'h104, 32'h0, 32'h0};
    exp_cnt = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({count, dm_wd} !== {exp_cnt[k], exp_wd[k]}) begin
        n_fail++;
        $display("FAIL bp_drain_%0d: got cnt=%0d wd=%h, required cnt=%0d wd=%h",
                 k, count, dm_wd, exp_cnt[k], exp_wd[k]);
      end
      tick();
    end
  endtask

  task automatic test_forwarding();
    dm_ready = 1'b0;
    push_one(32'h5000, 32'h20, 32'h1);
    push_one(32'h5004, 32'h20, 32'h2);
    push_one(32'h5008, 32'h30, 32'h3);
    ld_addr = 32'h20;
    #1;
    n_checks++;
    if ({ld_hit, ld_data} !== {1'b1, 32'h2}) begin
      n_fail++;
      $display("FAIL fwd_youngest: got hit=%b data=%h, required hit=1 data=2", ld_hit, ld_data);
    end
    ld_addr = 32'h30;
    #1;
    n_checks++;
    if ({ld_hit, ld_data} !== {1'b1, 32'h3}) begin
      n_fail++;
      $display("FAIL fwd_single: got hit=%b data=%h, required hit=1 data=3", ld_hit, ld_data);
    end
    ld_addr = 32'h24;
    #1;
    n_checks++;
    if ({ld_hit, ld_data} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL fwd_miss: got hit=%b data=%h, required hit=0 data=0", ld_hit, ld_data);
    end
    dm_ready = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd_drain: got empty=%b, required 1", empty);
    end
    ld_addr = 32'h0;
  endtask

  task automatic test_push_pop_wrap();
    dm_ready = 1'b0;
    push_one(32'h6000, 32'h100, 32'h500);
    push_one(32'h6004, 32'h104, 32'h501);
    dm_ready = 1'b1;
    st_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      st_pc   = 32'h6000 + 4 * (i + 2);
      st_addr = 32'h100 + 4 * (i + 2);
      st_data = 32'h500 + i + 2;
      #1;
      n_checks++;
      if ({count, dm_wd} !== {3'd2, 32'h500 + i}) begin
        n_fail++;
        $display("FAIL wrap_step_%0d: got cnt=%0d wd=%h, required cnt=2 wd=%h",
                 i, count, dm_wd, 32'h500 + i);
      end
      tick();
    end
    st_valid = 1'b0;
    for (int i = 10; i < 12; i++) begin
      n_checks++;
      if (dm_wd !== 32'h500 + i) begin
        n_fail++;
        $display("FAIL wrap_tail_%0d: got wd=%h, required %h", i, dm_wd, 32'h500 + i);
      end
      tick();
    end
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_empty: got empty=%b, required 1", empty);
    end
  endtask

  task automatic test_async_reset();
    dm_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_one(32'h7000 + 4 * i, 32'h80 + 4 * i, 32'h900 + i);
    n_checks++;
    if (count !== 3'd3) begin
      n_fail++;
      $display("FAIL areset_fill: got cnt=%0d, required 3", count);
    end
    #2;
    reset = 1'b0;  // between edges: must act without a clock
    #1;
    n_checks++;
    if ({count, dm_we, st_ready, empty, dm_wd} !== {3'd0, 1'b0, 1'b1, 1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL areset_now: got cnt=%0d we=%b rdy=%b emp=%b wd=%h, required cnt=0 we=0 rdy=1 emp=1 wd=0",
               count, dm_we, st_ready, empty, dm_wd);
    end
    #1;
    reset = 1'b1;
    tick();
    push_one(32'h7100, 32'h44, 32'hA5A5);
    n_checks++;
    if ({dm_we, dm_A, dm_wd, count} !== {1'b1, 10'h11, 32'hA5A5, 3'd1}) begin
      n_fail++;
      $display("FAIL areset_after: got we=%b A=%h wd=%h cnt=%0d, required we=1 A=011 wd=a5a5 cnt=1",
               dm_we, dm_A, dm_wd, count);
    end
    dm_ready = 1'b1;
    tick();
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_drain: got empty=%b, required 1", empty);
    end
  endtask

  task automatic test_same_cycle_fwd();
    dm_ready = 1'b0;
    st_valid = 1'b1;
    st_pc    = 32'h8000;
    st_addr  = 32'h80;
    st_data  = 32'h77;
    ld_addr  = 32'h80;
    #1;
    n_checks++;
    if (ld_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_nofwd: got hit=%b, required 0", ld_hit);
    end
    tick();
    st_valid = 1'b0;
    #1;
    n_checks++;
    if ({ld_hit, ld_data} !== {1'b1, 32'h77}) begin
      n_fail++;
      $display("FAIL next_cycle_fwd: got hit=%b data=%h, required hit=1 data=77", ld_hit, ld_data);
    end
    dm_ready = 1'b1;
    tick();
    ld_addr = 32'h0;
  endtask

  // Random traffic: the model is a queue; forwarding scans it oldest->youngest.
  task automatic test_random();
    logic [31:0] e_pc, e_addr, e_wd, e_ld;
    logic        e_hit;
    int          sz;
    do_reset();
    q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      st_valid = ($urandom_range(0, 2) != 0);
      st_pc    = $urandom;
      st_addr  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2);
      st_data  = $urandom;
      ld_addr  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2);
      dm_ready = ($urandom_range(0, 9) < 6);
      #1;
      sz     = q.size();
      e_pc   = (sz > 0) ? q[0].pc   : 32'd0;
      e_addr = (sz > 0) ? q[0].addr : 32'd0;
      e_wd   = (sz > 0) ? q[0].data : 32'd0;
      e_hit  = 1'b0;
      e_ld   = 32'd0;
      foreach (q[i]) begin
        if (q[i].addr[11:2] == ld_addr[11:2]) begin
          e_hit = 1'b1;
          e_ld  = q[i].data;
        end
      end
      n_checks++;
      if ({count, st_ready, empty, dm_we, dm_pc, dm_addr, dm_A, dm_wd, ld_hit, ld_data} !==
          {3'(sz), sz != 4, sz == 0, sz != 0, e_pc, e_addr, e_addr[11:2], e_wd, e_hit, e_ld}) begin
        n_fail++;
        $display("FAIL random_cyc%0d: got cnt=%0d rdy=%b we=%b pc=%h addr=%h A=%h wd=%h hit=%b ld=%h, required cnt=%0d pc=%h addr=%h wd=%h hit=%b ld=%h",
                 cyc, count, st_ready, dm_we, dm_pc, dm_addr, dm_A, dm_wd, ld_hit, ld_data,
                 sz, e_pc, e_addr, e_wd, e_hit, e_ld);
      end
      if (sz > 0 && dm_ready) void'(q.pop_front());
      if (st_valid && sz < 4) q.push_back('{pc: st_pc, addr: st_addr, data: st_data});
      tick();
    end
    st_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    st_valid = 1'b0;
    st_pc    = '0;
    st_addr  = '0;
    st_data  = '0;
    ld_addr  = '0;
    dm_ready = 1'b0;
    test_reset();
    test_single_store();
    test_backpressure();
    test_forwarding();
    test_push_pop_wrap();
    test_async_reset();
    test_same_cycle_fwd();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
